// File: rtl/sha_compress_iter.sv
// Iterative SHA-256 compression core: UNROLL chained rounds per clock, message schedule expanded on the fly.
// Optional macro SHA_FEEDFORWARD_EN adds the saved IV into state_out; otherwise the raw final A..H is returned.
module sha_compress_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] state_in,
    input  logic [511:0] block_in,
    output logic         ready,
    output logic         done,
    output logic [255:0] state_out
);
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    // A full unroll makes the step wrap to zero, which keeps the counter pinned at 0.
    localparam logic [5:0] STEP = 6'(UNROLL);
    localparam logic [5:0] LAST = 6'(64 - UNROLL);

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 &&
        UNROLL != 16 && UNROLL != 32 && UNROLL != 64) begin : g_bad_unroll
        $error("sha_compress_iter: UNROLL must be 1, 2, 4, 8, 16, 32 or 64");
    end

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sml_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic                     fsm;
    logic [5:0]               cnt;
    logic [0:7][31:0]         work;
    logic [0:7][31:0]         work_nxt;
    logic [0:7][31:0]         result;
    logic [0:15][31:0]        win;
    logic [0:15][31:0]        win_nxt;
    logic [0:15+UNROLL][31:0] ext;
    logic [31:0]              a, b, c, d, e, f, g, h, t1, t2;
    logic [5:0]               idx;

    // The window always holds W[t..t+15]; extending it by UNROLL words covers every round in the chain.
    always_comb begin
        ext = '0;
        for (int j = 0; j < 16; j++) ext[j] = win[j];
        for (int j = 0; j < UNROLL; j++)
            ext[j+16] = sml_sig1(ext[j+14]) + ext[j+9] + sml_sig0(ext[j+1]) + ext[j];

        {a, b, c, d, e, f, g, h} = work;
        t1  = '0;
        t2  = '0;
        idx = cnt;
        for (int i = 0; i < UNROLL; i++) begin
            idx = cnt + 6'(i);
            t1 = h + big_sig1(e) + ((e & f) ^ (~e & g)) + K[idx] + ext[i];
            t2 = big_sig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            h = g;
            g = f;
            f = e;
            e = d + t1;
            d = c;
            c = b;
            b = a;
            a = t1 + t2;
        end
        work_nxt = {a, b, c, d, e, f, g, h};
        win_nxt  = ext[UNROLL +: 16];
    end

`ifdef SHA_FEEDFORWARD_EN
    logic [0:7][31:0] iv;

    always_ff @(posedge clk) begin
        if (fsm == IDLE && start) iv <= state_in;
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++) result[i] = iv[i] + work_nxt[i];
    end
`else
    assign result = work_nxt;
`endif

    assign ready = (fsm == IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= 1'b0;
            if (fsm == IDLE) begin
                if (start) begin
                    fsm <= BUSY;
                    cnt <= '0;
                end
            end else begin
                cnt <= cnt + STEP;
                if (cnt == LAST) begin
                    fsm       <= IDLE;
                    done      <= 1'b1;
                    state_out <= result;
                end
            end
        end
    end

    // Working registers need no reset: they are always reloaded on the accept edge.
    always_ff @(posedge clk) begin
        if (fsm == IDLE) begin
            if (start) begin
                work <= state_in;
                win  <= block_in;
            end
        end else begin
            work <= work_nxt;
            win  <= win_nxt;
        end
    end
endmodule

// File: tb/tb_sha_compress_iter.sv
// Bench for sha_compress_iter at UNROLL 1, 8 and 64: a directed vector table, then back-to-back and reset-abort sequences.
// Expected digests are either published SHA-256 constants or come from the bench's own reference compression function.
module tb_sha_compress_iter;
    localparam int MAX_WAIT = 200;

    localparam logic [255:0] ABC_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] BLK2 = {16{32'hdeadbeef}};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           sel;
        logic [255:0] iv;
        logic [511:0] blk;
        int           lat;
        logic [255:0] digest;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   start_v;
    logic [255:0] state_in;
    logic [511:0] block_in;
    wire  [2:0]   ready_v;
    wire  [2:0]   done_v;
    wire  [255:0] out_v [3];

    int   tests_run = 0;
    int   tests_failed = 0;
    int   done_count = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    sha_compress_iter #(.UNROLL(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .state_in(state_in), .block_in(block_in),
        .ready(ready_v[0]), .done(done_v[0]), .state_out(out_v[0]));

    sha_compress_iter #(.UNROLL(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .state_in(state_in), .block_in(block_in),
        .ready(ready_v[1]), .done(done_v[1]), .state_out(out_v[1]));

    sha_compress_iter #(.UNROLL(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .state_in(state_in), .block_in(block_in),
        .ready(ready_v[2]), .done(done_v[2]), .state_out(out_v[2]));

    always @(negedge clk) if (done_v[0]) done_count++;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward reference: full 64-word schedule first, then 64 rounds, no feedforward.
    function automatic logic [255:0] sw_compress(input logic [255:0] iv, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = iv[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // Brings a DUT result into digest form regardless of which build is compiled.
    function automatic logic [255:0] to_ff(input logic [255:0] out, input logic [255:0] iv);
`ifdef SHA_FEEDFORWARD_EN
        logic [255:0] unused_iv;
        unused_iv = iv;
        return out;
`else
        return add_words(out, iv);
`endif
    endfunction

    task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int sel, input logic [255:0] iv, input logic [511:0] blk,
                                  output int lat, output logic rdy);
        @(negedge clk);
        rdy          = ready_v[sel];
        state_in     = iv;
        block_in     = blk;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        lat = 0;
        while (!done_v[sel] && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_output(input string tag, input vec_t v, input int lat, input logic rdy);
        check_val({tag, "_ready_idle"}, 256'(rdy), 256'(1));
        check_val({tag, "_latency"}, 256'(lat), 256'(v.lat));
        check_val({tag, "_digest"}, to_ff(out_v[v.sel], v.iv), v.digest);
        check_val({tag, "_ready_at_done"}, 256'(ready_v[v.sel]), 256'(1));
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 256'(done_v[v.sel]), 256'(0));
        check_val({tag, "_hold"}, to_ff(out_v[v.sel], v.iv), v.digest);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        int           base;
        logic         rdy;
        logic [255:0] blk2_digest;

        blk2_digest = add_words(sw_compress(ABC_IV, BLK2), ABC_IV);
        vecs[0] = '{0, ABC_IV, ABC_BLK, 64, ABC_DIGEST};
        vecs[1] = '{1, ABC_IV, ABC_BLK, 8, ABC_DIGEST};
        vecs[2] = '{2, ABC_IV, ABC_BLK, 1, ABC_DIGEST};
        vecs[3] = '{0, 256'h0, 512'h0, 64, sw_compress(256'h0, 512'h0)};
        vecs[4] = '{0, 256'h0, 512'h0, 64, sw_compress(256'h0, 512'h0)};
        vecs[5] = '{1, ABC_IV, BLK2, 8, blk2_digest};

        reset_n  = 1'b0;
        start_v  = 3'b000;
        state_in = '0;
        block_in = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("reset_ready", 256'(ready_v), 256'(3'b111));
        check_val("reset_done", 256'(done_v), 256'(0));
        for (int i = 0; i < 3; i++) check_val($sformatf("reset_out%0d", i), out_v[i], 256'h0);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].iv, vecs[i].blk, lat, rdy);
            check_output($sformatf("vec%0d", i), vecs[i], lat, rdy);
        end

        repeat (10) @(negedge clk);
        check_val("idle_hold_out", to_ff(out_v[0], 256'h0), vecs[4].digest);
        check_val("idle_no_done", 256'(done_v), 256'(0));

        // start held high across two jobs; the inputs change right after the first accept
        base = done_count;
        @(negedge clk);
        state_in   = ABC_IV;
        block_in   = ABC_BLK;
        start_v[0] = 1'b1;
        @(negedge clk);
        check_val("b2b_first_busy", 256'(ready_v[0]), 256'(0));
        block_in = BLK2;
        lat = 0;
        while (!done_v[0] && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        check_val("b2b_first_latency", 256'(lat), 256'(64));
        check_val("b2b_first_digest", to_ff(out_v[0], ABC_IV), ABC_DIGEST);
        @(negedge clk);
        check_val("b2b_second_accept", 256'(ready_v[0]), 256'(0));
        start_v[0] = 1'b0;
        lat = 0;
        while (!done_v[0] && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
            start_v[0] = (lat % 7 == 3) && (lat < 50);
        end
        start_v[0] = 1'b0;
        check_val("b2b_second_latency", 256'(lat), 256'(64));
        check_val("b2b_second_digest", to_ff(out_v[0], ABC_IV), blk2_digest);
        repeat (80) @(negedge clk);
        check_val("b2b_done_count", 256'(done_count - base), 256'(2));
        check_val("b2b_idle_after", 256'(ready_v[0]), 256'(1));

        // abort with reset_n sampled low on the edge that would run round 30
        @(negedge clk);
        state_in   = ABC_IV;
        block_in   = ABC_BLK;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (30) @(negedge clk);
        base = done_count;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_val("abort_ready", 256'(ready_v[0]), 256'(1));
        check_val("abort_done", 256'(done_v[0]), 256'(0));
        check_val("abort_out", out_v[0], 256'h0);
        repeat (70) @(negedge clk);
        check_val("abort_no_done", 256'(done_count - base), 256'(0));
        check_val("abort_out_stays", out_v[0], 256'h0);
        apply_stimulus(0, ABC_IV, ABC_BLK, lat, rdy);
        check_output("after_abort", vecs[0], lat, rdy);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sha_compress_iter.md
# sha_compress_iter

Iterative SHA-256 compression core built from the combinational `sha_round` datapath. It takes a 256-bit chaining state and a 512-bit message block and runs all 64 rounds over multiple clocks. `UNROLL` chained round instances are evaluated per cycle, and the message schedule is generated on the fly. It sits between the job/nonce logic and the double-hash controller, with a start/ready/done handshake.

## Interface

- `UNROLL`, default 1: rounds per clock; legal values 1, 2, 4, 8, 16, 32, 64; others are a elaboration error.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request a compression; sampled only when `ready`=1.
- `state_in` in 256: initial state, A in [255:224] … H in [31:0].
- `block_in` in 512: message block, W0 in [511:480] … W15 in [31:0].
- `ready` out 1: core idle, `start` will be accepted.
- `done` out 1: one-cycle pulse, `state_out` newly valid.
- `state_out` out 256: result, same word order as `state_in`.

## Operation

- States: IDLE, BUSY. N = 64/UNROLL.
- IDLE:
  - `ready`=1.
  - `start`=1 at an edge: latch `state_in` into working regs A..H and into a saved-IV reg; latch `block_in` into a 16-word schedule window; round counter t←0; go BUSY.
- BUSY:
  - `ready`=0.
  - Each edge applies UNROLL chained rounds t..t+UNROLL-1. Kt comes from the internal 64-entry constant table. Wt is the window head for t<16, otherwise σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - The window shifts by UNROLL words; t←t+UNROLL.
  - On the edge completing round 63: write `state_out`, pulse `done`, go IDLE.
- Arithmetic: all additions modulo 2^32 per word; no carries between words.
- `start` while BUSY: ignored, not queued.
- `state_in`/`block_in` changes after the accept edge: no effect on the running job.
- `state_out` holds its value until the next `done`.
- Reset (`reset_n`=0 at an edge), including mid-BUSY:
  - Aborts the job and enters IDLE.
  - `ready`=1, `done`=0, `state_out`=0, t=0.
  - No `done` is emitted for the aborted job.

## Timing

- Start accepted at edge E0. Rounds execute at E0+1 … E0+N. `done`=1 and `state_out` valid after E0+N, for exactly one cycle.
- `ready` rises on the same edge as `done`, so the next `start` can be sampled at E0+N+1. Sustained throughput is one block per N+1 cycles.
- UNROLL=1 gives 65 cycles start-to-start, 64-cycle latency. UNROLL=8 gives 9 and 8.
- Critical path is UNROLL chained rounds plus the schedule expander; no retiming inside the chain.

## Configuration

- `SHA_FEEDFORWARD_EN` defined: `state_out` = saved IV + final A..H, wordwise mod 2^32. This is the standard compression output, usable directly as the next chaining value or digest.
- Undefined: `state_out` = raw final A..H after round 63; the saved-IV register is removed and the caller performs the addition.
- Timing and handshake are identical in both builds.

## Test plan

- "abc", UNROLL=1, feedforward on:
  - Stimulus: `state_in`=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; `block_in`=61626380, 14×00000000, 00000018.
  - Response: `done` exactly 64 cycles after accept; `state_out`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same vector with UNROLL=8 and UNROLL=64 → identical `state_out`, with `done` 8 and 1 cycles after accept.
- Feedforward off, same vector → `state_out` + IV (wordwise mod 2^32) equals the digest above.
- `start` held high continuously with two different blocks → second accepted exactly one cycle after the first `done`. `start` pulses during BUSY are ignored, and `done` count equals accepted jobs.
- `reset_n` low for one edge at round 30 → next cycle `ready`=1, `done`=0, `state_out`=0. A fresh "abc" job then produces the correct digest.
- All-zero `state_in` and `block_in` → result matches the software model and reproduces across repeated runs. `state_out` holds stable between `done` pulses.
